// File: rtl/load_store_unit_if.sv
// Req/ack data-memory bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory stage: runs one byte/half/word access per memory instruction on a req/ack bus,
// steering store lanes, extending load data and stalling the core until done, fault or timeout.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              memwrite,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       alu_addr,
    input  logic [31:0]       write_data,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [31:0]       load_data,
    load_store_unit_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

    state_t      state;
    logic [7:0]  count;
    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_sext;

    logic        legal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    // Decode the incoming request: alignment check, lane enables and replicated store data.
    always_comb begin
        legal      = 1'b0;
        be_next    = 4'b0000;
        wdata_next = write_data;
        case (size)
            2'b00: begin
                legal      = 1'b1;
                be_next    = 4'b0001 << alu_addr[1:0];
                wdata_next = {4{write_data[7:0]}};
            end
            2'b01: begin
                legal      = ~alu_addr[0];
                be_next    = 4'b0011 << {alu_addr[1], 1'b0};
                wdata_next = {2{write_data[15:0]}};
            end
            2'b10: begin
                legal      = (alu_addr[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = write_data;
            end
            default: begin
                legal      = 1'b0;
                be_next    = 4'b0000;
                wdata_next = write_data;
            end
        endcase
    end

    always_comb begin
        rd_byte  = mem.mem_rdata[7:0];
        rd_half  = lat_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        load_ext = mem.mem_rdata;
        case (lat_off)
            2'b00:   rd_byte = mem.mem_rdata[7:0];
            2'b01:   rd_byte = mem.mem_rdata[15:8];
            2'b10:   rd_byte = mem.mem_rdata[23:16];
            default: rd_byte = mem.mem_rdata[31:24];
        endcase
        case (lat_size)
            2'b00:   load_ext = {{24{lat_sext & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{lat_sext & rd_half[15]}}, rd_half};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    assign stall = (state == REQ) || (state == IDLE && req_valid && legal);

    // Bus outputs are held from registered copies for the whole REQ phase and are zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= 8'd0;
            lat_off       <= 2'b00;
            lat_size      <= 2'b00;
            lat_sext      <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
            load_data     <= 32'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_be    <= 4'b0000;
            mem.mem_wdata <= 32'd0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (legal) begin
                            state         <= REQ;
                            count         <= 8'd0;
                            lat_off       <= alu_addr[1:0];
                            lat_size      <= size;
                            lat_sext      <= sign_ext;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= memwrite;
                            mem.mem_addr  <= {alu_addr[31:2], 2'b00};
                            mem.mem_be    <= be_next;
                            mem.mem_wdata <= wdata_next;
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // An ack on the last allowed cycle still completes the access.
                    if (mem.mem_ack || count == 8'(TIMEOUT - 1)) begin
                        if (mem.mem_ack) begin
                            state <= DONE;
                            done  <= 1'b1;
                            if (!mem.mem_we) begin
                                load_data <= load_ext;
                            end
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                        count         <= 8'd0;
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= 32'd0;
                        mem.mem_be    <= 4'b0000;
                        mem.mem_wdata <= 32'd0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model checked every cycle,
// directed cases pinned to hand-computed values, then randomized accesses.
module tb_load_store_unit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        memwrite;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] alu_addr;
    logic [31:0] write_data;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] load_data;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .memwrite   (memwrite),
        .size       (size),
        .sign_ext   (sign_ext),
        .alu_addr   (alu_addr),
        .write_data (write_data),
        .stall      (stall),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        done;
        logic        fault;
        logic [31:0] load_data;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } expect_t;

    typedef struct {
        int          stall_cycles;
        int          done_n;
        int          fault_n;
        int          req_n;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obs_t;

    expect_t     expected;
    obs_t        obs;
    bit          check_on = 1'b0;
    logic [31:0] model_ld = 32'd0;
    int          pass_count = 0;
    int          total_count = 0;

    // Reference rules written from the access definition, not from the RTL structure.
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit is_legal(input logic [1:0] sz, input logic [31:0] addr);
        if (sz == 2'b11) return 1'b0;
        return (addr % nbytes(sz)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
        int n;
        int off;
        n   = nbytes(sz);
        off = int'(addr % 4);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(sz);
        r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
        end
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] addr,
                                               input logic [31:0] rdata, input bit sx);
        logic [63:0] v;
        logic [63:0] full;
        int n;
        int off;
        n    = nbytes(sz);
        off  = int'(addr % 4);
        full = 64'd1 << (8 * n);
        v    = {32'd0, rdata >> (8 * off)} & (full - 64'd1);
        if (sx && v[8 * n - 1]) v = v - full;
        return v[31:0];
    endfunction

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
        total_count++;
        if (got === want) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    task automatic checkOutput();
        compare("stall",     32'(stall),         32'(expected.stall));
        compare("done",      32'(done),          32'(expected.done));
        compare("fault",     32'(fault),         32'(expected.fault));
        compare("load_data", load_data,          expected.load_data);
        compare("mem_req",   32'(bus.mem_req),   32'(expected.req));
        compare("mem_we",    32'(bus.mem_we),    32'(expected.we));
        compare("mem_addr",  bus.mem_addr,       expected.addr);
        compare("mem_be",    32'(bus.mem_be),    32'(expected.be));
        compare("mem_wdata", bus.mem_wdata,      expected.wdata);
    endtask

    always @(negedge clk) begin
        if (check_on) checkOutput();
    end

    task automatic expect_quiet();
        expected           = '{default: '0};
        expected.load_data = model_ld;
    endtask

    task automatic expect_req(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd);
        expect_quiet();
        expected.stall = 1'b1;
        expected.req   = 1'b1;
        expected.we    = wr;
        expected.addr  = addr & ~32'd3;
        expected.be    = model_be(sz, addr);
        expected.wdata = model_wdata(sz, wd);
    endtask

    // Let the compare process see this cycle, record what the bus did, move to the next drive slot.
    task automatic cycle_end();
        @(negedge clk);
        if (stall) obs.stall_cycles++;
        if (done) obs.done_n++;
        if (fault) obs.fault_n++;
        if (bus.mem_req) begin
            obs.req_n++;
            obs.we    = bus.mem_we;
            obs.addr  = bus.mem_addr;
            obs.be    = bus.mem_be;
            obs.wdata = bus.mem_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid      = 1'b0;
            bus.mem_ack    = 1'($urandom_range(0, 1));
            bus.mem_rdata  = $urandom;
            expect_quiet();
            cycle_end();
        end
        bus.mem_ack = 1'b0;
    endtask

    // One memory instruction; ack_wait wait cycles precede the ack, >= TIMEOUT means no ack.
    task automatic applyStimulus(input bit wr, input logic [1:0] sz, input bit sx,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int ack_wait);
        bit legal;
        bit acked;
        int req_cycles;
        obs   = '{default: '0};
        legal = is_legal(sz, addr);
        acked = 1'b0;

        req_valid     = 1'b1;
        memwrite      = wr;
        size          = sz;
        sign_ext      = sx;
        alu_addr      = addr;
        write_data    = wd;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        expect_quiet();
        expected.stall = legal;
        cycle_end();

        if (legal) begin
            acked      = (ack_wait < TIMEOUT);
            req_cycles = acked ? ack_wait + 1 : TIMEOUT;
            for (int c = 1; c <= req_cycles; c++) begin
                bus.mem_ack   = acked && (c == req_cycles);
                bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
                expect_req(wr, sz, addr, wd);
                cycle_end();
            end
            if (acked && !wr) model_ld = model_load(sz, addr, rdata, sx);
        end

        // Core advances here; whatever it presents now must not start an access.
        req_valid     = 1'($urandom_range(0, 1));
        memwrite      = 1'($urandom_range(0, 1));
        size          = 2'($urandom_range(0, 3));
        alu_addr      = $urandom;
        write_data    = $urandom;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        expect_quiet();
        expected.done  = legal && acked;
        expected.fault = !(legal && acked);
        cycle_end();

        req_valid   = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] ld_before;
        reset         = 1'b1;
        req_valid     = 1'b0;
        memwrite      = 1'b0;
        size          = 2'b00;
        sign_ext      = 1'b0;
        alu_addr      = 32'd0;
        write_data    = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        model_ld = 32'd0;
        check_on = 1'b1;
        expect_quiet();
        compare("reset_load_data", load_data, 32'd0);
        compare("reset_mem_req", 32'(bus.mem_req), 32'd0);
        idle_cycles(2);

        $display("[TB] word store with two wait cycles");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2);
        compare("t1_stall_cycles", 32'(obs.stall_cycles), 32'd4);
        compare("t1_done_pulses", 32'(obs.done_n), 32'd1);
        compare("t1_addr", obs.addr, 32'h100);
        compare("t1_be", 32'(obs.be), 32'hF);
        compare("t1_wdata", obs.wdata, 32'hDEADBEEF);
        compare("t1_we", 32'(obs.we), 32'd1);
        compare("t1_load_data", load_data, 32'd0);
        idle_cycles(1);

        $display("[TB] byte loads with sign and zero extension");
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FFFFFF, 0);
        compare("t2_sext", load_data, 32'hFFFFFF80);
        compare("t2_stall_cycles", 32'(obs.stall_cycles), 32'd2);
        compare("t2_req_cycles", 32'(obs.req_n), 32'd1);
        compare("t2_be", 32'(obs.be), 32'h8);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FFFFFF, 1);
        compare("t2_zext", load_data, 32'h00000080);

        $display("[TB] half store lane steering");
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234ABCD, 32'h0, 0);
        compare("t3_addr", obs.addr, 32'h4);
        compare("t3_be", 32'(obs.be), 32'hC);
        compare("t3_wdata", obs.wdata, 32'hABCDABCD);
        compare("t3_load_data", load_data, 32'h00000080);

        $display("[TB] misaligned and illegal-size accesses");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 0);
        compare("t4_fault_pulses", 32'(obs.fault_n), 32'd1);
        compare("t4_stall_cycles", 32'(obs.stall_cycles), 32'd0);
        compare("t4_req_cycles", 32'(obs.req_n), 32'd0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 0);
        compare("t4_size11_fault", 32'(obs.fault_n), 32'd1);
        compare("t4_size11_req", 32'(obs.req_n), 32'd0);
        idle_cycles(1);

        $display("[TB] timeout and last-cycle ack");
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h40, 32'h0, 32'h12345678, 100);
        compare("t5_req_cycles", 32'(obs.req_n), 32'd16);
        compare("t5_fault_pulses", 32'(obs.fault_n), 32'd1);
        compare("t5_done_pulses", 32'(obs.done_n), 32'd0);
        compare("t5_load_data", load_data, 32'h00000080);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h40, 32'h0, 32'h87654321, TIMEOUT - 1);
        compare("t5_late_ack_done", 32'(obs.done_n), 32'd1);
        compare("t5_late_ack_data", load_data, 32'h87654321);

        $display("[TB] reset during REQ");
        obs           = '{default: '0};
        req_valid     = 1'b1;
        memwrite      = 1'b0;
        size          = 2'b10;
        sign_ext      = 1'b0;
        alu_addr      = 32'h80;
        write_data    = 32'h0;
        bus.mem_ack   = 1'b0;
        expect_quiet();
        expected.stall = 1'b1;
        cycle_end();
        for (int c = 0; c < 2; c++) begin
            bus.mem_ack = 1'b0;
            expect_req(1'b0, 2'b10, 32'h80, 32'h0);
            cycle_end();
        end
        check_on      = 1'b0;
        reset         = 1'b1;
        req_valid     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        model_ld = 32'd0;
        compare("t6_mem_req_after_reset", 32'(bus.mem_req), 32'd0);
        check_on = 1'b1;
        obs      = '{default: '0};
        for (int c = 0; c < 3; c++) begin
            bus.mem_ack = 1'b1;
            expect_quiet();
            cycle_end();
        end
        bus.mem_ack = 1'b0;
        compare("t6_no_done", 32'(obs.done_n), 32'd0);
        compare("t6_no_fault", 32'(obs.fault_n), 32'd0);
        compare("t6_load_data", load_data, 32'd0);

        $display("[TB] randomized accesses");
        for (int t = 0; t < 150; t++) begin
            int wait_n;
            case ($urandom_range(0, 9))
                7:       wait_n = TIMEOUT - 1;
                8:       wait_n = TIMEOUT;
                9:       wait_n = int'($urandom_range(0, TIMEOUT));
                default: wait_n = int'($urandom_range(0, 3));
            endcase
            ld_before = model_ld;
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, wait_n);
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
            if (t == 149) compare("rand_model_tracks", load_data, model_ld);
            if (ld_before !== model_ld && obs.done_n != 1) begin
                compare("rand_update_needs_done", 32'(obs.done_n), 32'd1);
            end
        end

        check_on = 1'b0;
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
